lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_ctrl_if.sv | 11 +
 rtl/lcd_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_if.sv
// Panel-side bus of the character LCD controller (HD44780-style 8-bit write port).
interface lcd_ctrl_if;
  logic       lcd_on_o;
  logic       lcd_rs_o;
  logic       lcd_rw_o;
  logic       lcd_en_o;
  logic [7:0] lcd_data_o;

  modport master (output lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o);
  modport slave  (input  lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o);
endinterface

// File: rtl/lcd_ctrl.sv
// Character LCD write controller: toggle-triggered requests, one-entry pending slot.
// Define LCD_CTRL_INIT_EN to add the power-up wait and built-in panel init sequence.
module lcd_ctrl #(
  parameter int T_PWRUP = 750000,
  parameter int T_SETUP = 2,
  parameter int T_EN    = 12,
  parameter int T_CMD   = 2000,
  parameter int T_CLR   = 82000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lcd_word_i,
  lcd_ctrl_if.master  lcd_if,
  output logic        busy_o,
  output logic        ovf_o
);

  localparam int CntMax0 = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
  localparam int CntMax  = (CntMax0 > T_CMD) ? CntMax0 : T_CMD;
  localparam int CntW    = $clog2(CntMax + 1);

`ifdef LCD_CTRL_INIT_EN
  typedef enum logic [2:0] {PWRUP, INIT, IDLE, SETUP, PULSE, WAIT} state_t;
  localparam state_t ResetState = PWRUP;
  localparam logic   ResetBusy  = 1'b1;
`else
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, WAIT} state_t;
  localparam state_t ResetState = IDLE;
  localparam logic   ResetBusy  = 1'b0;
`endif

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tog_q;
  logic            slotFull_q, slotFull_d;
  logic            slotRs_q, slotRs_d;
  logic [7:0]      slotData_q, slotData_d;
  logic            ovf_q, ovf_d;
  logic            en_q, en_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            on_q;
  logic            busy_q, busy_d;
  logic            req, consume, isClr;
  logic [CntW-1:0] waitLast;
  logic            unusedBits;

`ifdef LCD_CTRL_INIT_EN
  logic [2:0] initIdx_q, initIdx_d;

  function automatic logic [7:0] initCmd(input logic [1:0] idx);
    case (idx)
      2'd0:    initCmd = 8'h38;
      2'd1:    initCmd = 8'h0C;
      2'd2:    initCmd = 8'h01;
      default: initCmd = 8'h06;
    endcase
  endfunction
`endif

  assign unusedBits = ^{lcd_word_i[30:11], lcd_word_i[8]};

  // Clear and home are slow on the panel, so they get the long post-strobe wait.
  assign isClr    = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));
  assign waitLast = isClr ? CntW'(T_CLR - 1) : CntW'(T_CMD - 1);

  always_comb begin
    req        = lcd_word_i[10] ^ tog_q;
    consume    = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    en_d       = en_q;
    rs_d       = rs_q;
    data_d     = data_q;
    slotFull_d = slotFull_q;
    slotRs_d   = slotRs_q;
    slotData_d = slotData_q;
    ovf_d      = ovf_q;
`ifdef LCD_CTRL_INIT_EN
    initIdx_d  = initIdx_q;
`endif
    case (state_q)
`ifdef LCD_CTRL_INIT_EN
      PWRUP: begin
        if (cnt_q == CntW'(T_PWRUP - 1)) begin
          state_d = INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      INIT: begin
        state_d = SETUP;
        rs_d    = 1'b0;
        data_d  = initCmd(initIdx_q[1:0]);
        cnt_d   = '0;
      end
`endif
      IDLE: begin
        if (slotFull_q) begin
          consume = 1'b1;
          state_d = SETUP;
          rs_d    = slotRs_q;
          data_d  = slotData_q;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == CntW'(T_SETUP - 1)) begin
          state_d = PULSE;
          en_d    = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == CntW'(T_EN - 1)) begin
          state_d = WAIT;
          en_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == waitLast) begin
          state_d = IDLE;
          cnt_d   = '0;
`ifdef LCD_CTRL_INIT_EN
          if (initIdx_q != 3'd4) begin
            initIdx_d = initIdx_q + 3'd1;
            if (initIdx_q != 3'd3) state_d = INIT;
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ResetState;
    endcase

    // A slot being drained this cycle can accept a new request without overflow.
    if (req) begin
      if (!slotFull_q || consume) begin
        slotFull_d = 1'b1;
        slotRs_d   = lcd_word_i[9];
        slotData_d = lcd_word_i[7:0];
      end else begin
        ovf_d = 1'b1;
      end
    end else if (consume) begin
      slotFull_d = 1'b0;
    end

    busy_d = (state_d != IDLE) || slotFull_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ResetState;
      cnt_q      <= '0;
      tog_q      <= 1'b0;
      slotFull_q <= 1'b0;
      slotRs_q   <= 1'b0;
      slotData_q <= 8'h00;
      ovf_q      <= 1'b0;
      en_q       <= 1'b0;
      rs_q       <= 1'b0;
      data_q     <= 8'h00;
      on_q       <= 1'b0;
      busy_q     <= ResetBusy;
`ifdef LCD_CTRL_INIT_EN
      initIdx_q  <= 3'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tog_q      <= lcd_word_i[10];
      slotFull_q <= slotFull_d;
      slotRs_q   <= slotRs_d;
      slotData_q <= slotData_d;
      ovf_q      <= ovf_d;
      en_q       <= en_d;
      rs_q       <= rs_d;
      data_q     <= data_d;
      on_q       <= lcd_word_i[31];
      busy_q     <= busy_d;
`ifdef LCD_CTRL_INIT_EN
      initIdx_q  <= initIdx_d;
`endif
    end
  end

  assign lcd_if.lcd_on_o   = on_q;
  assign lcd_if.lcd_rs_o   = rs_q;
  assign lcd_if.lcd_rw_o   = 1'b0;
  assign lcd_if.lcd_en_o   = en_q;
  assign lcd_if.lcd_data_o = data_q;
  assign busy_o            = busy_q;
  assign ovf_o             = ovf_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl with short timing parameters; follows the
// LCD_CTRL_INIT_EN setting of the build to choose init or no-init expectations.
module tb_lcd_ctrl;
  localparam int TPwrup  = 10;
  localparam int TSetup  = 1;
  localparam int TEn     = 2;
  localparam int TCmd    = 5;
  localparam int TClr    = 20;
  localparam int BusyCmd = 1 + TSetup + TEn + TCmd;
  localparam int BusyClr = 1 + TSetup + TEn + TClr;
`ifdef LCD_CTRL_INIT_EN
  localparam int ResetBusy = 1;
`else
  localparam int ResetBusy = 0;
`endif

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [31:0] word = 32'h8000_0000;
  logic        busy, ovf;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          n;
  int          k;

  lcd_ctrl_if lcdIf();

  lcd_ctrl #(
    .T_PWRUP(TPwrup), .T_SETUP(TSetup), .T_EN(TEn), .T_CMD(TCmd), .T_CLR(TClr)
  ) dut (
    .clk_i(clk), .rst_i(rst), .lcd_word_i(word), .lcd_if(lcdIf),
    .busy_o(busy), .ovf_o(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: records every EN strobe with its data and edge cycles.
  typedef struct { int data; int rs; int rise; int fall; } pulse_t;
  pulse_t pulses[$];
  int     curData, curRs, curRise, busyFall;
  logic   enPrev = 1'b0, busyPrev = 1'b0;

  always @(negedge clk) begin
    if (lcdIf.lcd_en_o && !enPrev) begin
      curData = int'(lcdIf.lcd_data_o);
      curRs   = int'(lcdIf.lcd_rs_o);
      curRise = cyc;
    end
    if (!lcdIf.lcd_en_o && enPrev) pulses.push_back('{curData, curRs, curRise, cyc});
    if (!busy && busyPrev) busyFall = cyc;
    enPrev   = lcdIf.lcd_en_o;
    busyPrev = busy;
  end

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic       expRs;
    logic [7:0] expData;
    int         expWidth;
    int         expBusy;
  } vec_t;
  vec_t vecs[9];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rs, input logic [7:0] data);
    word[10]  = ~word[10];
    word[9]   = rs;
    word[7:0] = data;
  endtask

  task automatic waitIdle(input string name, output int cnt);
    int lim;
    cnt = 0;
    lim = 0;
    while (lim < 300) begin
      tick();
      if (!busy) break;
      cnt++;
      lim++;
    end
    if (busy) checkOutput({name, "_timeout"}, int'(busy), 0);
  endtask

  task automatic doReset();
    rst  = 1'b1;
    word = 32'h8000_0000;
    #1;
    checkOutput("rst_en", int'(lcdIf.lcd_en_o), 0);
    checkOutput("rst_ovf", int'(ovf), 0);
    checkOutput("rst_busy", int'(busy), ResetBusy);
    tick();
    tick();
    checkOutput("rst_rs", int'(lcdIf.lcd_rs_o), 0);
    checkOutput("rst_data", int'(lcdIf.lcd_data_o), 0);
    checkOutput("rst_on", int'(lcdIf.lcd_on_o), 0);
    checkOutput("rst_rw", int'(lcdIf.lcd_rw_o), 0);
    rst = 1'b0;
    pulses.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 8'h41, 1'b1, 8'h41, TEn, BusyCmd};
    vecs[1] = '{1'b0, 8'h80, 1'b0, 8'h80, TEn, BusyCmd};
    vecs[2] = '{1'b1, 8'h00, 1'b1, 8'h00, TEn, BusyCmd};
    vecs[3] = '{1'b1, 8'hFF, 1'b1, 8'hFF, TEn, BusyCmd};
    vecs[4] = '{1'b0, 8'h01, 1'b0, 8'h01, TEn, BusyClr};
    vecs[5] = '{1'b0, 8'h02, 1'b0, 8'h02, TEn, BusyClr};
    vecs[6] = '{1'b0, 8'h03, 1'b0, 8'h03, TEn, BusyCmd};
    vecs[7] = '{1'b1, 8'h01, 1'b1, 8'h01, TEn, BusyCmd};
    vecs[8] = '{1'b1, 8'h02, 1'b1, 8'h02, TEn, BusyCmd};

    doReset();

`ifdef LCD_CTRL_INIT_EN
    waitIdle("init", n);
    checkOutput("init_busy_cycles", n,
                TPwrup + 3 * (1 + TSetup + TEn + TCmd) + (1 + TSetup + TEn + TClr) - 1);
    checkOutput("init_count", pulses.size(), 4);
    for (int i = 0; i < pulses.size() && i < 4; i++) begin
      checkOutput($sformatf("init%0d_data", i), pulses[i].data,
                  (i == 0) ? 'h38 : (i == 1) ? 'h0C : (i == 2) ? 'h01 : 'h06);
      checkOutput($sformatf("init%0d_rs", i), pulses[i].rs, 0);
      checkOutput($sformatf("init%0d_width", i), pulses[i].fall - pulses[i].rise, TEn);
    end
    if (pulses.size() == 4) begin
      checkOutput("init_gap_cmd", pulses[1].rise - pulses[0].fall, TCmd + 1 + TSetup);
      checkOutput("init_gap_clr", pulses[3].rise - pulses[2].fall, TClr + 1 + TSetup);
      checkOutput("init_busy_fall", busyFall - pulses[3].fall, TCmd);
    end
`else
    tick();
    applyStimulus(1'b1, 8'h41);
    waitIdle("noinit", n);
    checkOutput("noinit_busy_cycles", n, BusyCmd);
    checkOutput("noinit_count", pulses.size(), 1);
    if (pulses.size() > 0) begin
      checkOutput("noinit_data", pulses[0].data, 'h41);
      checkOutput("noinit_rs", pulses[0].rs, 1);
    end
`endif
    checkOutput("on_follow", int'(lcdIf.lcd_on_o), 1);

    for (int i = 0; i < 9; i++) begin
      pulses.delete();
      applyStimulus(vecs[i].rs, vecs[i].data);
      waitIdle($sformatf("vec%0d", i), n);
      checkOutput($sformatf("vec%0d_busy", i), n, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d_count", i), pulses.size(), 1);
      if (pulses.size() > 0) begin
        checkOutput($sformatf("vec%0d_data", i), pulses[0].data, int'(vecs[i].expData));
        checkOutput($sformatf("vec%0d_rs", i), pulses[0].rs, int'(vecs[i].expRs));
        checkOutput($sformatf("vec%0d_width", i), pulses[0].fall - pulses[0].rise, vecs[i].expWidth);
      end
      checkOutput($sformatf("vec%0d_hold_data", i), int'(lcdIf.lcd_data_o), int'(vecs[i].expData));
      checkOutput($sformatf("vec%0d_en_idle", i), int'(lcdIf.lcd_en_o), 0);
    end

    word[31] = 1'b0;
    tick();
    checkOutput("on_low", int'(lcdIf.lcd_on_o), 0);
    word[31] = 1'b1;
    tick();
    checkOutput("on_high", int'(lcdIf.lcd_on_o), 1);

    // Same word toggled twice back-to-back: two writes, no overflow.
    pulses.delete();
    applyStimulus(1'b1, 8'h41);
    tick();
    applyStimulus(1'b1, 8'h41);
    waitIdle("twice", n);
    checkOutput("twice_count", pulses.size(), 2);
    for (int i = 0; i < pulses.size() && i < 2; i++)
      checkOutput($sformatf("twice%0d_data", i), pulses[i].data, 'h41);
    checkOutput("twice_ovf", int'(ovf), 0);

    // Three requests on consecutive cycles: the third finds the slot full.
    pulses.delete();
    applyStimulus(1'b1, 8'h41);
    tick();
    applyStimulus(1'b1, 8'h42);
    tick();
    applyStimulus(1'b1, 8'h43);
    tick();
    checkOutput("ovf_set", int'(ovf), 1);
    waitIdle("ovf", n);
    checkOutput("ovf_count", pulses.size(), 2);
    if (pulses.size() >= 2) begin
      checkOutput("ovf_first", pulses[0].data, 'h41);
      checkOutput("ovf_second", pulses[1].data, 'h42);
    end
    repeat (5) tick();
    checkOutput("ovf_sticky", int'(ovf), 1);

    // Reset in the middle of an EN pulse.
    pulses.delete();
    applyStimulus(1'b1, 8'h55);
    k = 0;
    while (k < 20 && !lcdIf.lcd_en_o) begin
      tick();
      k++;
    end
    checkOutput("midrst_pulse_reached", int'(lcdIf.lcd_en_o), 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_en_low", int'(lcdIf.lcd_en_o), 0);
    checkOutput("midrst_ovf", int'(ovf), 0);
    checkOutput("midrst_busy", int'(busy), ResetBusy);
    word[10] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    pulses.delete();
`ifdef LCD_CTRL_INIT_EN
    k = 0;
    while (k < 100 && pulses.size() == 0) begin
      tick();
      k++;
    end
    checkOutput("midrst_restart_seen", int'(pulses.size() > 0), 1);
    if (pulses.size() > 0) begin
      checkOutput("midrst_restart_data", pulses[0].data, 'h38);
      checkOutput("midrst_restart_rs", pulses[0].rs, 0);
    end
    waitIdle("midrst_init", n);
`else
    repeat (40) tick();
    checkOutput("midrst_no_retry", pulses.size(), 0);
    checkOutput("midrst_idle", int'(busy), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
